// File: rtl/led_pkg.sv
// Shared constants for the multi-channel LED blinker: channel modes and width helpers.
package led_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler; emits a registered one-cycle tick every TICK_MAX+1 cycles.
module tick_gen #(
  parameter int unsigned TICK_MAX = 49_999
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic tick
);

  localparam int unsigned PW = led_pkg::ch_width(TICK_MAX + 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          tick_q;
  logic          at_max;

  assign at_max = (pcnt_q == PW'(TICK_MAX));

  always_comb begin
    pcnt_d = at_max ? '0 : pcnt_q + 1'b1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= at_max;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_blinker_multi.sv
// Multi-channel LED driver: shared tick, per-channel OFF/ON/BLINK/BURST with run-time config.
module led_blinker_multi
  import led_pkg::*;
#(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned TICK_MAX   = 49_999,
  parameter int unsigned PER_W      = 12,
  parameter int unsigned BST_W      = 8,
  parameter logic [1:0]  RST_MODE   = MODE_BLINK,
  parameter int unsigned RST_PERIOD = 500,
  localparam int unsigned CH_W      = ch_width(CH_NUM)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic [BST_W-1:0]  cfg_burst,
  output logic [CH_NUM-1:0] led_out,
  output logic [CH_NUM-1:0] burst_done,
  output logic              tick
);

  tick_gen #(
    .TICK_MAX(TICK_MAX)
  ) u_tick_gen (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .tick   (tick)
  );

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [1:0]       mode_q, mode_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [PER_W-1:0] ph_q, ph_d;
    logic [PER_W-1:0] p_m1;
    logic [BST_W-1:0] rem_q, rem_d;
    logic             led_q, led_d;
    logic             done_q, done_d;
    logic             hit;

    // Out-of-range channel numbers match no channel, so such writes are dropped.
    assign hit  = cfg_wr && (cfg_ch == CH_W'(i));
    assign p_m1 = (per_q == '0) ? '0 : per_q - 1'b1;

    always_comb begin
      mode_d = mode_q;
      per_d  = per_q;
      ph_d   = ph_q;
      rem_d  = rem_q;
      led_d  = led_q;
      done_d = 1'b0;
      if (hit) begin
        mode_d = cfg_mode;
        per_d  = cfg_period;
        rem_d  = cfg_burst;
        ph_d   = '0;
        led_d  = (cfg_mode != MODE_OFF);
        if (cfg_mode == MODE_BURST && cfg_burst == '0) begin
          mode_d = MODE_OFF;
          led_d  = 1'b0;
          done_d = 1'b1;
        end
      end else begin
        unique case (mode_q)
          MODE_OFF: begin
            led_d = 1'b0;
            ph_d  = '0;
          end
          MODE_ON: begin
            led_d = 1'b1;
            ph_d  = '0;
          end
          default: begin
            if (tick) begin
              if (ph_q == p_m1) begin
                ph_d  = '0;
                led_d = ~led_q;
                // Each falling edge consumes one burst pulse; the last one retires the channel.
                if (mode_q == MODE_BURST && led_q) begin
                  rem_d = rem_q - 1'b1;
                  if (rem_q <= BST_W'(1)) begin
                    rem_d  = '0;
                    mode_d = MODE_OFF;
                    done_d = 1'b1;
                  end
                end
              end else begin
                ph_d = ph_q + 1'b1;
              end
            end
          end
        endcase
      end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        mode_q <= RST_MODE;
        per_q  <= PER_W'(RST_PERIOD);
        ph_q   <= '0;
        rem_q  <= '0;
        led_q  <= 1'b0;
        done_q <= 1'b0;
      end else begin
        mode_q <= mode_d;
        per_q  <= per_d;
        ph_q   <= ph_d;
        rem_q  <= rem_d;
        led_q  <= led_d;
        done_q <= done_d;
      end
    end

    assign led_out[i]    = led_q;
    assign burst_done[i] = done_q;
  end

endmodule

// File: tb/tb_led_blinker_multi.sv
// Randomized bench for led_blinker_multi against a tick-count reference model (4- and 3-channel DUTs).
module tb_led_blinker_multi;

  localparam int unsigned TM    = 3;
  localparam int unsigned PER_W = 12;
  localparam int unsigned BST_W = 8;
  localparam int unsigned RP    = 2;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             cfg_wr = 1'b0;
  logic [1:0]       cfg_ch = '0;
  logic [1:0]       cfg_mode = '0;
  logic [PER_W-1:0] cfg_period = '0;
  logic [BST_W-1:0] cfg_burst = '0;
  logic [3:0]       led4, done4;
  logic [2:0]       led3, done3;
  logic             tick4, tick3;

  always #5 sys_clk = ~sys_clk;

  led_blinker_multi #(
    .CH_NUM(4), .TICK_MAX(TM), .PER_W(PER_W), .BST_W(BST_W),
    .RST_MODE(2'b10), .RST_PERIOD(RP)
  ) u_dut4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_burst(cfg_burst),
    .led_out(led4), .burst_done(done4), .tick(tick4)
  );

  led_blinker_multi #(
    .CH_NUM(3), .TICK_MAX(TM), .PER_W(PER_W), .BST_W(BST_W),
    .RST_MODE(2'b10), .RST_PERIOD(RP)
  ) u_dut3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_burst(cfg_burst),
    .led_out(led3), .burst_done(done3), .tick(tick3)
  );

  // Model: a toggling channel's level is its start level flipped once per P ticks elapsed.
  int m_mode[2][4];
  int m_per[2][4];
  int m_n[2][4];
  int m_start[2][4];
  int m_bst[2][4];
  bit m_done[2][4];
  int cyc;
  int n_tests = 0;
  int n_fail = 0;

  function automatic int eff(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  function automatic bit tick_at(input int c);
    return (c > 0) && (c % (TM + 1) == 0);
  endfunction

  function automatic int nch(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_mode[k][i]  = 2;
        m_per[k][i]   = RP;
        m_n[k][i]     = 0;
        m_start[k][i] = 0;
        m_bst[k][i]   = 0;
        m_done[k][i]  = 1'b0;
      end
    end
    cyc = 0;
  endtask

  task automatic model_edge();
    bit t;
    t = tick_at(cyc);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < nch(k); i++) begin
        m_done[k][i] = 1'b0;
        if (cfg_wr && int'(cfg_ch) == i) begin
          m_mode[k][i]  = int'(cfg_mode);
          m_per[k][i]   = int'(cfg_period);
          m_bst[k][i]   = int'(cfg_burst);
          m_n[k][i]     = 0;
          m_start[k][i] = (cfg_mode != 2'b00) ? 1 : 0;
          if (cfg_mode == 2'b11 && cfg_burst == '0) begin
            m_mode[k][i]  = 0;
            m_start[k][i] = 0;
            m_done[k][i]  = 1'b1;
          end
        end else if (m_mode[k][i] >= 2 && t) begin
          m_n[k][i]++;
          // Burst starts high, so falls completed = ceil(half-periods / 2).
          if (m_mode[k][i] == 3 &&
              (m_n[k][i] / eff(m_per[k][i]) + 1) / 2 >= m_bst[k][i]) begin
            m_mode[k][i]  = 0;
            m_start[k][i] = 0;
            m_n[k][i]     = 0;
            m_done[k][i]  = 1'b1;
          end
        end
      end
    end
    cyc++;
  endtask

  function automatic logic [31:0] exp_led(input int k);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nch(k); i++) begin
      if (m_mode[k][i] == 1) v[i] = 1'b1;
      else if (m_mode[k][i] >= 2)
        v[i] = 1'(m_start[k][i] ^ ((m_n[k][i] / eff(m_per[k][i])) & 1));
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_done(input int k);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nch(k); i++) v[i] = m_done[k][i];
    return v;
  endfunction

  task automatic compare_all();
    check_eq("led4", {28'b0, led4}, exp_led(0));
    check_eq("done4", {28'b0, done4}, exp_done(0));
    check_eq("tick4", {31'b0, tick4}, {31'b0, tick_at(cyc)});
    check_eq("led3", {29'b0, led3}, exp_led(1));
    check_eq("done3", {29'b0, done3}, exp_done(1));
    check_eq("tick3", {31'b0, tick3}, {31'b0, tick_at(cyc)});
  endtask

  task automatic step(input logic wr, input logic [1:0] ch, input logic [1:0] md,
                      input logic [PER_W-1:0] per, input logic [BST_W-1:0] bst);
    cfg_wr     = wr;
    cfg_ch     = ch;
    cfg_mode   = md;
    cfg_period = per;
    cfg_burst  = bst;
    @(posedge sys_clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 2'd0, 2'd0, '0, '0);
  endtask

  task automatic check_in_reset();
    check_eq("rst_led4", {28'b0, led4}, 32'd0);
    check_eq("rst_done4", {28'b0, done4}, 32'd0);
    check_eq("rst_tick4", {31'b0, tick4}, 32'd0);
    check_eq("rst_led3", {29'b0, led3}, 32'd0);
    check_eq("rst_tick3", {31'b0, tick3}, 32'd0);
  endtask

  initial begin
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    check_in_reset();
    sys_rst = 1'b0;

    // Reset-state blink: rises after P ticks, toggles every P ticks.
    idle(40);

    step(1'b1, 2'd1, 2'b11, 12'd1, 8'd3);
    idle(30);
    step(1'b1, 2'd2, 2'b11, 12'd2, 8'd0);
    idle(2);
    step(1'b1, 2'd0, 2'b01, 12'd0, 8'd0);
    idle(2);
    step(1'b1, 2'd0, 2'b00, 12'd0, 8'd0);
    idle(2);
    step(1'b1, 2'd0, 2'b10, 12'd0, 8'd0);
    idle(12);

    // Write landing on a tick cycle; ch3 is out of range for the 3-channel DUT.
    for (int j = 0; j < 8 && !tick_at(cyc); j++) idle(1);
    step(1'b1, 2'd3, 2'b10, 12'd2, 8'd0);
    idle(12);

    for (int j = 0; j < 1500; j++) begin
      if ($urandom_range(0, 3) == 0)
        step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             12'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
      else
        idle(1);
    end

    // Asynchronous reset in the middle of a burst.
    step(1'b1, 2'd1, 2'b11, 12'd3, 8'd5);
    idle(10);
    #2 sys_rst = 1'b1;
    #1;
    check_in_reset();
    @(negedge sys_clk);
    check_in_reset();
    model_reset();
    sys_rst = 1'b0;
    idle(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
